// File: rtl/uart_rx_pkg.sv
// Shared widths for the UART receiver slice.
package uart_rx_pkg;

  localparam int unsigned DataBits = 8;
  localparam int unsigned AddrW    = 3;

  typedef logic [DataBits-1:0] byte_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-edge detect, mid-bit sampling, stop check, and a slot index
// for writing received bytes into an 8-entry message buffer.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 9600
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx,
  output logic [7:0]       data,
  output logic             valid,
  output logic [AddrW-1:0] addr,
  output logic             frame_err,
  output logic             busy
);

  localparam int unsigned DIV  = CLK_FREQ / BAUD;
  localparam int unsigned CntW = $clog2(DIV);

  localparam logic [CntW-1:0] HalfLast = CntW'(DIV / 2 - 1);
  localparam logic [CntW-1:0] FullLast = CntW'(DIV - 1);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } state_e;

  state_e         state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      bit_idx_q;
  byte_t           shift_q;
  byte_t           data_q;
  logic            valid_q;
  logic            frame_err_q;
  logic [AddrW-1:0] addr_q;
  logic            rx_s;
  logic            rx_prev_q;

  sync2 u_sync2 (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      addr_q      <= '0;
      rx_prev_q   <= 1'b1;
    end else begin
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      rx_prev_q   <= rx_s;
      // addr names the slot of data while valid is high, then moves on.
      if (valid_q) begin
        addr_q <= addr_q + 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          // Edge-based so a line held low after a frame error never restarts.
          if (rx_prev_q && !rx_s) begin
            state_q <= StStart;
            cnt_q   <= '0;
          end
        end
        StStart: begin
          if (cnt_q == HalfLast) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            state_q   <= rx_s ? StIdle : StData;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StData: begin
          if (cnt_q == FullLast) begin
            cnt_q              <= '0;
            shift_q[bit_idx_q] <= rx_s;
            bit_idx_q          <= bit_idx_q + 1'b1;
            if (bit_idx_q == 3'd7) begin
              state_q <= StStop;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StStop: begin
          if (cnt_q == FullLast) begin
            cnt_q   <= '0;
            state_q <= StIdle;
            if (rx_s) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign addr      = addr_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Randomized bench for uart_rx: frames are scheduled against an expected-event queue
// built from the line protocol, and a negedge monitor matches every output pulse.
module tb_uart_rx;

  localparam int unsigned ClkFreq = 16;
  localparam int unsigned Baud    = 1;
  localparam int unsigned Div     = ClkFreq / Baud;
  // Drive-to-pulse: two sync flops, the edge cycle, stop sample, registered pulse.
  localparam int unsigned Latency = 2 + 1 + Div / 2 + 9 * Div;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic [2:0] addr;
  logic       frame_err;
  logic       busy;

  uart_rx #(
    .CLK_FREQ (ClkFreq),
    .BAUD     (Baud)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .addr      (addr),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_err;
    logic [7:0]  data;
    logic [2:0]  addr;
    int unsigned cyc;
  } exp_t;

  exp_t       exp_q[$];
  int         model_slot = 0;
  logic [7:0] model_data = 8'h00;
  int         n_checks   = 0;
  int         n_errors   = 0;
  logic [7:0] prev_data  = 8'h00;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Caller must be aligned to posedge+1; returns aligned, with the stop level still driven.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    exp_t e;
    e.cyc    = cyc + Latency;
    e.is_err = !stop_ok;
    e.addr   = model_slot[2:0];
    if (stop_ok) begin
      e.data     = b;
      model_data = b;
      model_slot = (model_slot + 1) % 8;
    end else begin
      e.data = model_data;
    end
    exp_q.push_back(e);
    rx = 1'b0;
    hold(Div);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      hold(Div);
    end
    rx = stop_ok;
    hold(Div);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    hold(2);
    rst = 1'b0;
    check_eq("queue_drained_before_reset", exp_q.size(), 0);
    exp_q.delete();
    model_slot = 0;
    model_data = 8'h00;
    hold(1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (data !== prev_data) check_eq("data_change_without_valid", valid, 1);
      if (valid || frame_err) begin
        check_eq("valid_and_frame_err_together", valid & frame_err, 0);
        if (exp_q.size() == 0) begin
          check_eq("unexpected_pulse_valid_ferr", {valid, frame_err}, 2'b00);
        end else begin
          e = exp_q.pop_front();
          check_eq("pulse_kind_frame_err", frame_err, e.is_err);
          check_eq("pulse_data", data, e.data);
          check_eq("pulse_addr", addr, e.addr);
          check_eq("pulse_cycle", cyc, e.cyc);
        end
      end
    end
    prev_data = data;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, pending=%0d", exp_q.size());
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] msg [8];
    logic [7:0] ab;
    int         kind;
    msg = '{8'h5B, 8'h46, 8'h50, 8'h47, 8'h41, 8'h5D, 8'h0D, 8'h0A};

    hold(3);
    rst = 1'b0;
    hold(1);
    check_eq("reset_data", data, 8'h00);
    check_eq("reset_valid", valid, 0);
    check_eq("reset_frame_err", frame_err, 0);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_addr", addr, 0);

    // Single byte
    fork
      send_frame(8'h5B, 1'b1);
      begin
        hold(40);
        check_eq("busy_mid_frame", busy, 1);
      end
    join
    hold(3);
    check_eq("addr_after_first", addr, 1);
    check_eq("busy_after_first", busy, 0);

    // Back-to-back message with addr wrap
    do_reset();
    for (int i = 0; i < 8; i++) send_frame(msg[i], 1'b1);
    hold(3);
    check_eq("addr_wrapped", addr, 0);
    check_eq("data_last_msg", data, 8'h0A);

    // Glitch on the start bit
    rx = 1'b0;
    hold(4);
    check_eq("busy_during_glitch", busy, 1);
    rx = 1'b1;
    hold(2 * Div);
    check_eq("busy_after_glitch", busy, 0);
    check_eq("addr_after_glitch", addr, model_slot);

    // Frame error with the line held low
    send_frame(8'hA5, 1'b0);
    hold(50);
    check_eq("data_after_ferr", data, model_data);
    check_eq("addr_after_ferr", addr, model_slot);
    check_eq("busy_line_held_low", busy, 0);
    rx = 1'b1;
    hold(Div);
    send_frame(8'hC3, 1'b1);
    hold(3);
    check_eq("data_recovered", data, 8'hC3);

    // Reset during data bit 4 of 0x3C
    do_reset();
    ab = 8'h3C;
    rx = 1'b0;
    hold(Div);
    for (int i = 0; i < 4; i++) begin
      rx = ab[i];
      hold(Div);
    end
    rx = ab[4];
    hold(Div / 2);
    rst = 1'b1;
    hold(1);
    rst = 1'b0;
    hold(2 * Div);
    check_eq("busy_after_abort", busy, 0);
    check_eq("data_after_abort", data, 8'h00);
    send_frame(8'h41, 1'b1);
    hold(3);
    check_eq("data_after_abort_rx", data, 8'h41);
    check_eq("addr_after_abort_rx", addr, 1);

    // Randomized traffic
    for (int n = 0; n < 30; n++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        rx = 1'b0;
        hold($urandom_range(1, 6));
        rx = 1'b1;
        hold(2 * Div);
        check_eq("rand_busy_after_glitch", busy, 0);
      end else if (kind == 1) begin
        send_frame(8'($urandom_range(0, 255)), 1'b0);
        hold(Div + $urandom_range(0, 30));
        rx = 1'b1;
        hold(2 + $urandom_range(0, 5));
      end else begin
        send_frame(8'($urandom_range(0, 255)), 1'b1);
        hold($urandom_range(0, 5));
      end
    end

    hold(Latency);
    check_eq("pending_expected_pulses", exp_q.size(), 0);
    check_eq("final_addr", addr, model_slot);
    check_eq("final_data", data, model_data);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
